des_req_arbiter: RTL

DES_REQ_ARBITER -- requirements
Module: des_req_arbiter

---
 rtl/des_req_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/des_req_arbiter.sv
// Two-requester front end for des_top: groups blocks by {key, encrypt} context,
// reloads the key schedule only on context changes, and routes results back in issue order.
module des_req_arbiter #(
  parameter int MAX_OUT    = 16,
  parameter int FAIR_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:64] req0_data,
  input  logic [1:64] req0_key,
  input  logic        req0_encrypt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:64] req1_data,
  input  logic [1:64] req1_key,
  input  logic        req1_encrypt,
  output logic        rsp0_valid,
  output logic [1:64] rsp0_data,
  output logic        rsp1_valid,
  output logic [1:64] rsp1_data,
  output logic        des_encrypt,
  output logic [1:64] des_keys_64,
  output logic        des_change_keys_en,
  input  logic        des_subkeys_16_valid,
  output logic        des_data_input_en,
  output logic [1:64] des_data_64_in,
  input  logic [1:64] des_data_64_out,
  input  logic        des_data_output_valid,
  output logic        busy,
  output logic        err
);

  localparam int PTR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W  = $clog2(MAX_OUT + 1);
  localparam int FAIR_W = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;

  typedef enum logic [2:0] {IDLE, DRAIN, KEY_LOAD, KEY_WAIT, STREAM} state_t;

  state_t            state_q;
  logic [1:64]       ctx_key_q;
  logic              ctx_enc_q;
  logic              ctx_valid_q;
  logic              target_q;
  logic              rr_q;
  logic [FAIR_W-1:0] fair_q;
  logic [CNT_W-1:0]  out_cnt_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [1:0]        wait_q;
  logic              chg_q;
  logic              err_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic [1:64]       rsp0_data_q;
  logic [1:64]       rsp1_data_q;
  logic              tag_mem [MAX_OUT];

  logic [1:0] vld, hit, m, mis;
  logic       idle_win, grant, drain_tgt, exit_idle, exit_drain, issue, pop, fair_full, pop_tag;

  assign vld       = {req1_valid, req0_valid};
  assign hit[0]    = ctx_valid_q && (req0_key == ctx_key_q) && (req0_encrypt == ctx_enc_q);
  assign hit[1]    = ctx_valid_q && (req1_key == ctx_key_q) && (req1_encrypt == ctx_enc_q);
  assign m         = vld & hit;
  assign mis       = vld & ~hit;
  assign fair_full = (fair_q == FAIR_W'(FAIR_LIMIT));
  assign pop       = des_data_output_valid && (out_cnt_q != '0);
  assign pop_tag   = tag_mem[rd_ptr_q];

  always_comb begin
    idle_win   = (vld == 2'b11) ? ~rr_q : vld[1];
    grant      = (m == 2'b11) ? ~rr_q : m[1];
    drain_tgt  = (mis == 2'b11) ? ~rr_q : mis[1];
    exit_idle  = (state_q == STREAM) && (vld == 2'b00);
    // A waiting foreign context wins once it has been passed over FAIR_LIMIT times.
    exit_drain = (state_q == STREAM) && (mis != 2'b00) && ((m == 2'b00) || fair_full);
    issue      = (state_q == STREAM) && (m != 2'b00) && !exit_drain
                 && (out_cnt_q < CNT_W'(MAX_OUT));
  end

  assign req0_ready         = issue && !grant;
  assign req1_ready         = issue && grant;
  assign des_data_input_en  = issue;
  assign des_data_64_in     = !issue ? '0 : (grant ? req1_data : req0_data);
  assign des_keys_64        = ctx_key_q;
  assign des_encrypt        = ctx_enc_q;
  assign des_change_keys_en = chg_q;
  assign rsp0_valid         = rsp0_valid_q;
  assign rsp1_valid         = rsp1_valid_q;
  assign rsp0_data          = rsp0_data_q;
  assign rsp1_data          = rsp1_data_q;
  assign err                = err_q;
  assign busy               = (state_q != IDLE) || (out_cnt_q != '0);

  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr_q] <= grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ctx_key_q    <= '0;
      ctx_enc_q    <= 1'b0;
      ctx_valid_q  <= 1'b0;
      target_q     <= 1'b0;
      rr_q         <= 1'b0;
      fair_q       <= '0;
      out_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wait_q       <= '0;
      chg_q        <= 1'b0;
      err_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      chg_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vld != 2'b00) begin
            if (ctx_valid_q && hit[idle_win]) begin
              state_q <= STREAM;
            end else begin
              state_q  <= DRAIN;
              target_q <= idle_win;
            end
          end
        end
        DRAIN: begin
          if (out_cnt_q == '0) state_q <= KEY_LOAD;
        end
        KEY_LOAD: begin
          ctx_key_q   <= target_q ? req1_key : req0_key;
          ctx_enc_q   <= target_q ? req1_encrypt : req0_encrypt;
          ctx_valid_q <= 1'b1;
          fair_q      <= '0;
          chg_q       <= 1'b1;
          wait_q      <= '0;
          state_q     <= KEY_WAIT;
        end
        KEY_WAIT: begin
          // The first two cycles may still show the old schedule's valid flag.
          if (wait_q != 2'd2) begin
            wait_q <= wait_q + 2'd1;
          end else if (des_subkeys_16_valid) begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (exit_idle) begin
            state_q <= IDLE;
          end else if (exit_drain) begin
            state_q  <= DRAIN;
            target_q <= drain_tgt;
          end
          if (issue) begin
            rr_q <= grant;
            if (!mis[!grant])   fair_q <= '0;
            else if (!fair_full) fair_q <= fair_q + FAIR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      if (issue) wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (issue && !pop)      out_cnt_q <= out_cnt_q + CNT_W'(1);
      else if (!issue && pop) out_cnt_q <= out_cnt_q - CNT_W'(1);

      if (des_data_output_valid && (out_cnt_q == '0)) err_q <= 1'b1;

      rsp0_valid_q <= pop && !pop_tag;
      rsp1_valid_q <= pop && pop_tag;
      if (pop && !pop_tag) rsp0_data_q <= des_data_64_out;
      if (pop && pop_tag)  rsp1_data_q <= des_data_64_out;
    end
  end

endmodule
